// File: rtl/sync_pulse_arbiter_pkg.sv
// Shared types and helpers for the slow-to-fast pulse synchronizer arbiter.
package sync_pulse_arbiter_pkg;

    // Transfer sequencing: grant, stretched pulse, optional ack wait, optional gap.
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StHold    = 2'd1,
        StWaitAck = 2'd2,
        StGap     = 2'd3
    } arb_state_e;

    // Ceiling log2, never below 1 so vectors built from it stay legal.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/sync_pulse_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request after ptr, with wrap.
module rr_arbiter
    import sync_pulse_arbiter_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned IdW = clog2(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IdW-1:0] ptr_i,
    output logic [N-1:0]   gnt_o,
    output logic [IdW-1:0] idx_o
);

    logic found;

    // Scan ptr+1 .. ptr+N modulo N; the last-granted index has lowest priority.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            int unsigned j;
            j = (32'(ptr_i) + k) % N;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IdW'(j);
            end
        end
    end

endmodule

// File: rtl/sync_pulse_arbiter.sv
// Shares one slow-to-fast pulse synchronizer among N_REQ slow-domain requesters.
module sync_pulse_arbiter
    import sync_pulse_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned HOLD_CYC = 2,
    parameter int unsigned GAP_CYC  = 1,
    parameter bit          ACK_EN   = 1'b1,
    parameter int unsigned TO_CYC   = 15,
    localparam int unsigned ID_W    = clog2(N_REQ)
) (
    input  logic             clk_slow,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_in,
    input  logic             sync_ack,
    output logic             sync_pulse,
    output logic [ID_W-1:0]  sync_id,
    output logic [N_REQ-1:0] grant,
    output logic             busy,
    output logic [N_REQ-1:0] pending,
    output logic [N_REQ-1:0] coalesce,
    output logic             done_vld,
    output logic [ID_W-1:0]  done_id,
    output logic             done_err
);

    localparam int unsigned CntMax0 = (HOLD_CYC > TO_CYC) ? HOLD_CYC : TO_CYC;
    localparam int unsigned CntMax  = (CntMax0 > GAP_CYC) ? CntMax0 : GAP_CYC;
    localparam int unsigned CntW    = clog2(CntMax + 1);
    localparam logic [CntW-1:0] HoldLoad = CntW'(HOLD_CYC - 1);
    localparam logic [CntW-1:0] ToLoad   = CntW'(TO_CYC - 1);
    localparam logic [CntW-1:0] GapLoad  = (GAP_CYC > 0) ? CntW'(GAP_CYC - 1) : '0;

    arb_state_e       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  owner_q, owner_d;
    logic [N_REQ-1:0] pending_q, pending_d;
    logic [N_REQ-1:0] coalesce_q, coalesce_d;
    logic             pulse_q, pulse_d;
    logic [ID_W-1:0]  sync_id_q, sync_id_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             done_vld_q, done_vld_d;
    logic [ID_W-1:0]  done_id_q, done_id_d;
    logic             done_err_q, done_err_d;

    logic [N_REQ-1:0] arb_gnt;
    logic [ID_W-1:0]  arb_idx;
    logic [N_REQ-1:0] clr;
    logic             fin;
    logic             fin_err;

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr (
        .req_i (pending_q),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    // Next-state: FSM, shared down-counter, pending/coalesce, registered outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        grant_d    = grant_q;
        pulse_d    = 1'b0;
        sync_id_d  = '0;
        done_vld_d = 1'b0;
        done_id_d  = '0;
        done_err_d = 1'b0;
        clr        = '0;
        fin        = 1'b0;
        fin_err    = 1'b0;

        unique case (state_q)
            StIdle: begin
                grant_d = '0;
                if (|pending_q) begin
                    state_d   = StHold;
                    cnt_d     = HoldLoad;
                    clr       = arb_gnt;
                    ptr_d     = arb_idx;
                    owner_d   = arb_idx;
                    grant_d   = arb_gnt;
                    pulse_d   = 1'b1;
                    sync_id_d = arb_idx;
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    if (ACK_EN) begin
                        state_d = StWaitAck;
                        cnt_d   = ToLoad;
                    end else begin
                        fin = 1'b1;
                    end
                end else begin
                    cnt_d     = cnt_q - 1'b1;
                    pulse_d   = 1'b1;
                    sync_id_d = owner_q;
                end
            end
            StWaitAck: begin
                // An ack on the expiry cycle still counts as success.
                if (sync_ack) begin
                    fin = 1'b1;
                end else if (cnt_q == '0) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StGap: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (fin) begin
            done_vld_d = 1'b1;
            done_id_d  = owner_q;
            done_err_d = fin_err;
            grant_d    = '0;
            if (GAP_CYC > 0) begin
                state_d = StGap;
                cnt_d   = GapLoad;
            end else begin
                state_d = StIdle;
            end
        end

        // A request arriving on its own grant edge survives the clear.
        pending_d  = (pending_q & ~clr) | req_in;
        coalesce_d = req_in & pending_q & ~clr;
    end

    // State register with synchronous active-low reset; reset aborts without done_vld.
    always_ff @(posedge clk_slow) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            ptr_q      <= ID_W'(N_REQ - 1);
            owner_q    <= '0;
            pending_q  <= '0;
            coalesce_q <= '0;
            pulse_q    <= 1'b0;
            sync_id_q  <= '0;
            grant_q    <= '0;
            done_vld_q <= 1'b0;
            done_id_q  <= '0;
            done_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            pending_q  <= pending_d;
            coalesce_q <= coalesce_d;
            pulse_q    <= pulse_d;
            sync_id_q  <= sync_id_d;
            grant_q    <= grant_d;
            done_vld_q <= done_vld_d;
            done_id_q  <= done_id_d;
            done_err_q <= done_err_d;
        end
    end

    assign sync_pulse = pulse_q;
    assign sync_id    = sync_id_q;
    assign grant      = grant_q;
    assign busy       = (state_q != StIdle);
    assign pending    = pending_q;
    assign coalesce   = coalesce_q;
    assign done_vld   = done_vld_q;
    assign done_id    = done_id_q;
    assign done_err   = done_err_q;

endmodule

// File: tb/tb_sync_pulse_arbiter.sv
// Directed bench: DUT a uses defaults, DUT b has ACK_EN=0 and GAP_CYC=0.
module tb_sync_pulse_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req_a = '0, req_b = '0;
    logic       ack_a = 1'b0, ack_b = 1'b0;

    logic       pulse_a, busy_a, dv_a, err_a;
    logic [1:0] id_a, did_a;
    logic [3:0] grant_a, pend_a, coal_a;
    logic       pulse_b, busy_b, dv_b, err_b;
    logic [1:0] id_b, did_b;
    logic [3:0] grant_b, pend_b, coal_b;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       err;
        logic [1:0] id;
    } done_t;
    done_t dq_a[$];

    typedef struct packed {
        logic [3:0] req;
        logic       ack;
        logic       pulse;
        logic [1:0] id;
        logic [3:0] grant;
        logic       busy;
        logic [3:0] pend;
        logic       dv;
        logic [1:0] did;
        logic       derr;
    } vec_t;
    vec_t tbl[9];

    always #5 clk = ~clk;

    sync_pulse_arbiter dut_a (
        .clk_slow   (clk),
        .rst_n      (rst_n),
        .req_in     (req_a),
        .sync_ack   (ack_a),
        .sync_pulse (pulse_a),
        .sync_id    (id_a),
        .grant      (grant_a),
        .busy       (busy_a),
        .pending    (pend_a),
        .coalesce   (coal_a),
        .done_vld   (dv_a),
        .done_id    (did_a),
        .done_err   (err_a)
    );

    sync_pulse_arbiter #(
        .GAP_CYC (0),
        .ACK_EN  (1'b0)
    ) dut_b (
        .clk_slow   (clk),
        .rst_n      (rst_n),
        .req_in     (req_b),
        .sync_ack   (ack_b),
        .sync_pulse (pulse_b),
        .sync_id    (id_b),
        .grant      (grant_b),
        .busy       (busy_b),
        .pending    (pend_b),
        .coalesce   (coal_b),
        .done_vld   (dv_b),
        .done_id    (did_b),
        .done_err   (err_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge and log completions of DUT a.
    task automatic tick();
        @(posedge clk);
        #1;
        if (dv_a) dq_a.push_back('{err_a, did_a});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_a = '0;
        req_b = '0;
        ack_a = 1'b0;
        ack_b = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        dq_a.delete();
    endtask

    initial begin
        logic [9:0] pexp_b;
        logic [9:0] dvexp_b;

        // req, ack, pulse, id, grant, busy, pend, dv, did, derr
        tbl[0] = '{4'b0100, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[1] = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0100, 1'b0, 2'd0, 1'b0};
        tbl[2] = '{4'b0000, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[3] = '{4'b0000, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[4] = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0100, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[5] = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0100, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[6] = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b0};
        tbl[7] = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[8] = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};

        // Reset state
        do_reset();
        chk("reset_pulse", 32'(pulse_a), 32'd0);
        chk("reset_busy", 32'(busy_a), 32'd0);
        chk("reset_grant", 32'(grant_a), 32'd0);
        chk("reset_done", 32'(dv_a), 32'd0);

        // Single request, table-driven; stray acks during HOLD/IDLE must be ignored
        for (int i = 0; i < 9; i++) begin
            tick();
            req_a = tbl[i].req;
            ack_a = tbl[i].ack;
            chk($sformatf("tbl%0d_pulse", i), 32'(pulse_a), 32'(tbl[i].pulse));
            chk($sformatf("tbl%0d_grant", i), 32'(grant_a), 32'(tbl[i].grant));
            chk($sformatf("tbl%0d_busy", i), 32'(busy_a), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d_pend", i), 32'(pend_a), 32'(tbl[i].pend));
            chk($sformatf("tbl%0d_dv", i), 32'(dv_a), 32'(tbl[i].dv));
            if (tbl[i].pulse) chk($sformatf("tbl%0d_id", i), 32'(id_a), 32'(tbl[i].id));
            if (tbl[i].dv) begin
                chk($sformatf("tbl%0d_did", i), 32'(did_a), 32'(tbl[i].did));
                chk($sformatf("tbl%0d_derr", i), 32'(err_a), 32'(tbl[i].derr));
            end
        end

        // Round-robin from reset: all four at once, ack held high
        do_reset();
        for (int c = 0; c < 40; c++) begin
            tick();
            req_a = (c == 0) ? 4'b1111 : 4'b0000;
            ack_a = 1'b1;
        end
        chk("rr_count", 32'(dq_a.size()), 32'd4);
        for (int k = 0; k < 4 && k < dq_a.size(); k++) begin
            chk($sformatf("rr_order%0d", k), 32'(dq_a[k].id), 32'(k));
            chk($sformatf("rr_err%0d", k), 32'(dq_a[k].err), 32'd0);
        end
        chk("rr_pending_drained", 32'(pend_a), 32'd0);
        chk("rr_idle", 32'(busy_a), 32'd0);

        // Timeout: HOLD cycles 2..3, WAIT_ACK 4..18, error completion in cycle 19
        do_reset();
        for (int c = 0; c < 22; c++) begin
            tick();
            req_a = (c == 0) ? 4'b0001 : 4'b0000;
            if (c == 2 || c == 3) chk($sformatf("to_pulse_c%0d", c), 32'(pulse_a), 32'd1);
            if (c >= 4 && c <= 18)
                chk($sformatf("to_wait_c%0d", c), 32'({pulse_a, dv_a, busy_a}), 32'b001);
            if (c == 18) chk("to_grant_held", 32'(grant_a), 32'b0001);
            if (c == 19) chk("to_done", 32'({dv_a, err_a, did_a}), 32'b1100);
        end

        // Coalesce while busy: req_in[1] on two consecutive cycles -> one grant only
        do_reset();
        for (int c = 0; c < 30; c++) begin
            tick();
            req_a = (c == 0) ? 4'b0001 : ((c == 2 || c == 3) ? 4'b0010 : 4'b0000);
            ack_a = 1'b1;
            if (c == 3) chk("coal_c3", 32'({pend_a, coal_a}), 32'h20);
            if (c == 4) chk("coal_c4", 32'(coal_a), 32'b0010);
            if (c == 5) chk("coal_c5", 32'(coal_a), 32'b0000);
        end
        chk("coal_count", 32'(dq_a.size()), 32'd2);
        if (dq_a.size() >= 2) chk("coal_second_id", 32'(dq_a[1].id), 32'd1);

        // Request on its own grant edge survives -> second grant follows
        do_reset();
        for (int c = 0; c < 30; c++) begin
            tick();
            req_a = (c == 0 || c == 1) ? 4'b0010 : 4'b0000;
            ack_a = 1'b1;
            if (c == 2) chk("regrant_c2", 32'({pend_a, coal_a}), 32'h20);
        end
        chk("regrant_count", 32'(dq_a.size()), 32'd2);
        if (dq_a.size() >= 2) chk("regrant_ids", 32'({dq_a[0].id, dq_a[1].id}), 32'b0101);

        // Mid-transfer reset during HOLD, then pointer must be back at N_REQ-1
        do_reset();
        for (int c = 0; c < 16; c++) begin
            tick();
            req_a = (c == 0) ? 4'b0100 : ((c == 10) ? 4'b1111 : 4'b0000);
            if (c == 2) begin
                chk("mid_hold_id", 32'({pulse_a, id_a}), 32'b110);
                rst_n = 1'b0;
            end
            if (c == 3) begin
                chk("mid_outputs", 32'({pulse_a, grant_a, busy_a, pend_a, dv_a, coal_a}), 32'd0);
                rst_n = 1'b1;
            end
            if (c == 9) chk("mid_no_done", 32'(dq_a.size()), 32'd0);
            if (c == 12) chk("mid_first_winner", 32'({pulse_a, id_a}), 32'b100);
        end

        // ACK_EN=0, GAP_CYC=0: back-to-back transfers, stray ack held high
        do_reset();
        pexp_b  = 10'b0001101100;
        dvexp_b = 10'b0010010000;
        for (int c = 0; c < 10; c++) begin
            tick();
            req_b = (c == 0) ? 4'b0011 : 4'b0000;
            ack_b = 1'b1;
            chk($sformatf("b_pulse_c%0d", c), 32'(pulse_b), 32'(pexp_b[c]));
            chk($sformatf("b_dv_c%0d", c), 32'(dv_b), 32'(dvexp_b[c]));
            if (c == 2) chk("b_id_c2", 32'(id_b), 32'd0);
            if (c == 5) chk("b_id_c5", 32'(id_b), 32'd1);
            if (c == 4) chk("b_done_c4", 32'({did_b, err_b, grant_b, busy_b}), 32'd0);
            if (c == 7) chk("b_done_c7", 32'({did_b, err_b}), 32'b010);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
